// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch PC owner and pipeline-advance sequencer for a 5-stage
//               core (DX redirects, load-use bubbles, multdiv stalls).
//               Optional macro PC_SEQ_STATS_EN adds redirect/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module pc_sequencer #(
  parameter int                     PC_WIDTH      = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC      = '0,
  parameter int                     MD_MAX_CYCLES = 40
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                branch_jump_taken,
  input  logic [PC_WIDTH-1:0] ctrl_PC,
  input  logic                load_use_hazard,
  input  logic                md_start,
  input  logic                md_ready,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                pc_we,
  output logic                fd_we,
  output logic                dx_we,
  output logic                flush_fd,
  output logic                flush_dx,
  output logic                md_stall,
  output logic                md_timeout
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [15:0]         redirect_count,
  output logic [15:0]         stall_count
`endif
);

  localparam int              CNT_W  = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MD_MAX = CNT_W'(MD_MAX_CYCLES);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  state_t              state_q,   state_d;
  logic [PC_WIDTH-1:0] pc_q,      pc_d;
  logic [CNT_W-1:0]    md_cnt_q,  md_cnt_d;
  logic                timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    md_cnt_d  = md_cnt_q;
    timeout_d = timeout_q;
    pc_we     = 1'b0;
    fd_we     = 1'b0;
    dx_we     = 1'b0;
    flush_fd  = 1'b0;
    flush_dx  = 1'b0;
    md_stall  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (branch_jump_taken) begin
          // Younger instrs in FD/DX are on the wrong path; squash both
          pc_we    = 1'b1;
          fd_we    = 1'b1;
          dx_we    = 1'b1;
          flush_fd = 1'b1;
          flush_dx = 1'b1;
          pc_d     = ctrl_PC;
        end else if (md_start) begin
          md_stall = 1'b1;
          state_d  = ST_MD_WAIT;
          md_cnt_d = CNT_W'(1);
        end else if (load_use_hazard) begin
          dx_we    = 1'b1;
          flush_dx = 1'b1;
        end else begin
          pc_we = 1'b1;
          fd_we = 1'b1;
          dx_we = 1'b1;
          pc_d  = pc_q + PC_WIDTH'(1);
        end
      end

      ST_MD_WAIT: begin
        if (md_ready || (md_cnt_q == MD_MAX)) begin
          // Forced release on timeout behaves exactly like a normal ready
          pc_we    = 1'b1;
          fd_we    = 1'b1;
          dx_we    = 1'b1;
          pc_d     = pc_q + PC_WIDTH'(1);
          state_d  = ST_RUN;
          md_cnt_d = '0;
          if (!md_ready) begin
            timeout_d = 1'b1;
          end
        end else begin
          md_stall = 1'b1;
          md_cnt_d = md_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = ST_RUN;
        md_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      md_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      md_cnt_q  <= md_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign pc_out     = pc_q;
  assign md_timeout = timeout_q;

`ifdef PC_SEQ_STATS_EN
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [15:0] stall_cnt_q,    stall_cnt_d;

  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if ((state_q == ST_RUN) && branch_jump_taken && (redirect_cnt_q != 16'hFFFF)) begin
      redirect_cnt_d = redirect_cnt_q + 16'd1;
    end
    if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_cnt_q <= 16'd0;
      stall_cnt_q    <= 16'd0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign redirect_count = redirect_cnt_q;
  assign stall_count    = stall_cnt_q;
`endif

endmodule

`default_nettype wire
